// File: rtl/lsb_pkg.sv
// lsb_pkg: shared types and helpers for the loop stream buffer.
//   lsb_state_e : controller states (IDLE, CAPTURE, REPLAY)
//   OPC_*       : RISC-V major opcodes for control-flow instructions
//   is_ctrl()   : 1 when an opcode redirects control flow
package lsb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPLAY  = 2'd2
  } lsb_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Classify an opcode as a control-flow instruction
  function automatic logic is_ctrl(input logic [6:0] opcode);
    logic ctrl_s;
    case (opcode)
      OPC_BRANCH, OPC_JAL, OPC_JALR: ctrl_s = 1'b1;
      default:                       ctrl_s = 1'b0;
    endcase
    return ctrl_s;
  endfunction

endpackage

// File: rtl/lsb_store.sv
// lsb_store: DEPTH x ILEN simple dual-port instruction store.
//   clk, reset         : clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr      : synchronous read request
//   rd_data            : read data, one cycle after rd_en; holds while rd_en=0
module lsb_store
  import lsb_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ILEN   = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ILEN-1:0]   wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ILEN-1:0]   rd_data
);

  logic [ILEN-1:0] mem_r [DEPTH];

  // Array write; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register; holding it while rd_en=0 is what freezes the replay stream on stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= {ILEN{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/loop_stream_buffer.sv
// loop_stream_buffer: fetch-stage loop buffer. Detects a short backward
// B-type/JAL loop, captures its body on the next pass, then replays it with
// fetch blocked until mispredict or disable.
//   lb_enable, fetch_valid, fetch_pc, fetch_instr, branch_imm : fetch side
//   stall, mispredict : downstream hold / branch resolution
//   lb_active, lb_valid, lb_instr, lb_pc : replay stream (registered)
//   flush, resume_pc  : one-cycle exit pulse and fetch restart PC
//   replay_count      : completed iterations, saturating
// All outputs are registered, so flush/resume appear the cycle after the
// exit condition is sampled, together with lb_active=0 and lb_valid=0.
module loop_stream_buffer
  import lsb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lb_enable,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [ILEN-1:0] fetch_instr,
  input  logic [XLEN-1:0] branch_imm,
  input  logic            stall,
  input  logic            mispredict,
  output logic            lb_active,
  output logic            lb_valid,
  output logic [ILEN-1:0] lb_instr,
  output logic [XLEN-1:0] lb_pc,
  output logic            flush,
  output logic [XLEN-1:0] resume_pc,
  output logic [15:0]     replay_count
);

  localparam logic [XLEN-1:0]   PC_STEP  = XLEN'(4);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  lsb_state_e        state_r, state_nx_s;
  logic [XLEN-1:0]   br_pc_r, tgt_pc_r, lb_pc_r, resume_pc_r;
  logic [ADDR_W-1:0] last_idx_r, wr_ptr_r, out_idx_r, rd_ptr_r;
  logic [15:0]       replay_count_r;
  logic              lb_active_r, lb_valid_r, flush_r;

  logic [6:0]        opcode_s;
  logic [XLEN-1:0]   neg_imm_s, exp_pc_s, next_pc_s;
  logic              candidate_s, at_br_s, cap_bad_s, wrap_s;
  logic              cap_start_s, cap_wr_s, rep_start_s, rep_adv_s, exit_mp_s, exit_dis_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s, wr_addr_s;

  assign opcode_s  = fetch_instr[6:0];
  assign neg_imm_s = -branch_imm;
  // N-1 = (-imm)>>2 must fit in the entry index range
  assign candidate_s = fetch_valid && ((opcode_s == OPC_BRANCH) || (opcode_s == OPC_JAL)) &&
                       branch_imm[XLEN-1] && ((neg_imm_s >> 2) < XLEN'(DEPTH));

  assign exp_pc_s  = tgt_pc_r + {{(XLEN-ADDR_W-2){1'b0}}, wr_ptr_r, 2'b00};
  assign at_br_s   = (fetch_pc == br_pc_r);
  // The last slot must be the branch itself; anything else means the body never closed
  assign cap_bad_s = (fetch_pc != exp_pc_s) || (is_ctrl(opcode_s) && !at_br_s) ||
                     ((wr_ptr_r == last_idx_r) && !at_br_s);

  assign wrap_s    = (out_idx_r == last_idx_r);
  assign next_pc_s = wrap_s ? tgt_pc_r : (lb_pc_r + PC_STEP);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_nx_s  = state_r;
    cap_start_s = 1'b0;
    cap_wr_s    = 1'b0;
    rep_start_s = 1'b0;
    rep_adv_s   = 1'b0;
    exit_mp_s   = 1'b0;
    exit_dis_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (candidate_s && lb_enable) begin
          state_nx_s  = CAPTURE;
          cap_start_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CAPTURE: begin
        if (mispredict || !lb_enable) begin
          state_nx_s = IDLE;
        end else if (fetch_valid) begin
          if (cap_bad_s) begin
            state_nx_s = IDLE;
          end else begin
            cap_wr_s = 1'b1;
            if (at_br_s) begin
              rep_start_s = 1'b1;
              state_nx_s  = REPLAY;
            end else begin
              state_nx_s = CAPTURE;
            end
          end
        end else begin
          state_nx_s = CAPTURE;
        end
      end
      REPLAY: begin
        if (mispredict) begin
          exit_mp_s  = 1'b1;
          state_nx_s = IDLE;
        end else if (!lb_enable) begin
          exit_dis_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          rep_adv_s  = !stall;
          state_nx_s = REPLAY;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  assign wr_addr_s = at_br_s ? last_idx_r : wr_ptr_r;
  assign rd_en_s   = rep_start_s || rep_adv_s;
  assign rd_addr_s = rep_start_s ? PTR_ZERO : rd_ptr_r;

  lsb_store #(.DEPTH(DEPTH), .ILEN(ILEN), .ADDR_W(ADDR_W)) u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cap_wr_s),
    .wr_addr (wr_addr_s),
    .wr_data (fetch_instr),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (lb_instr)
  );

  // Loop geometry, pointers and the registered replay/exit outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_pc_r        <= {XLEN{1'b0}};
      tgt_pc_r       <= {XLEN{1'b0}};
      last_idx_r     <= PTR_ZERO;
      wr_ptr_r       <= PTR_ZERO;
      out_idx_r      <= PTR_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      lb_pc_r        <= {XLEN{1'b0}};
      resume_pc_r    <= {XLEN{1'b0}};
      replay_count_r <= 16'h0000;
      lb_active_r    <= 1'b0;
      lb_valid_r     <= 1'b0;
      flush_r        <= 1'b0;
    end else begin
      if ((state_r == IDLE) && candidate_s) begin
        br_pc_r    <= fetch_pc;
        tgt_pc_r   <= fetch_pc + branch_imm;
        last_idx_r <= neg_imm_s[ADDR_W+1:2];
      end
      if (cap_start_s) begin
        wr_ptr_r       <= PTR_ZERO;
        replay_count_r <= 16'h0000;
      end else if (cap_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rep_start_s) begin
        out_idx_r   <= PTR_ZERO;
        rd_ptr_r    <= (last_idx_r == PTR_ZERO) ? PTR_ZERO : PTR_ONE;
        lb_pc_r     <= tgt_pc_r;
        lb_active_r <= 1'b1;
        lb_valid_r  <= 1'b1;
      end else if (rep_adv_s) begin
        out_idx_r <= wrap_s ? PTR_ZERO : (out_idx_r + PTR_ONE);
        rd_ptr_r  <= (rd_ptr_r == last_idx_r) ? PTR_ZERO : (rd_ptr_r + PTR_ONE);
        lb_pc_r   <= next_pc_s;
        if (wrap_s && (replay_count_r != 16'hFFFF)) begin
          replay_count_r <= replay_count_r + 16'h0001;
        end
      end
      if (exit_mp_s || exit_dis_s) begin
        lb_active_r <= 1'b0;
        lb_valid_r  <= 1'b0;
      end
      // A stalled entry was not consumed, so it is where fetch must restart
      if (exit_mp_s) begin
        resume_pc_r <= br_pc_r + PC_STEP;
      end else if (exit_dis_s) begin
        resume_pc_r <= stall ? lb_pc_r : next_pc_s;
      end
      flush_r <= exit_mp_s || exit_dis_s;
    end
  end

  assign lb_active    = lb_active_r;
  assign lb_valid     = lb_valid_r;
  assign lb_pc        = lb_pc_r;
  assign flush        = flush_r;
  assign resume_pc    = resume_pc_r;
  assign replay_count = replay_count_r;

endmodule

// File: doc/loop_stream_buffer.md
Name: loop_stream_buffer

Overview:
Parametrised loop buffer for the fetch stage of the RISC-V pipeline. It detects a short backward-taken B-type or JAL loop, captures the loop body into local storage, then replays it while blocking instruction fetch. On mispredict or disable it flushes and hands fetch back at the correct PC. Compared with the first-generation loop buffer, it adds depth/width parameters, a capture-integrity check, stall handling, a PC-tagged replay stream, an iteration counter and an enable control.

Parameters:
XLEN, 32, PC and immediate width
ILEN, 32, instruction width
DEPTH, 16, buffer entries; power of two, 4..64
ADDR_W, $clog2(DEPTH), entry pointer width (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
lb_enable  in  1  feature enable
fetch_valid  in  1  fetch_pc/fetch_instr valid this cycle
fetch_pc  in  XLEN  PC of fetched instruction
fetch_instr  in  ILEN  fetched instruction
branch_imm  in  XLEN  signed decoded immediate of fetch_instr
stall  in  1  downstream stall; hold replay stream
mispredict  in  1  branch resolved mispredicted
lb_active  out  1  fetch blocked, buffer is instruction source
lb_valid  out  1  lb_instr/lb_pc valid
lb_instr  out  ILEN  replayed instruction
lb_pc  out  XLEN  PC of replayed instruction
flush  out  1  one-cycle pulse on replay exit
resume_pc  out  XLEN  fetch restart PC, valid with flush
replay_count  out  16  completed replay iterations, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; pointers 0.
- Candidate: fetch_valid, opcode in {1100011, 1101111}, branch_imm[XLEN-1]=1, and N = (-branch_imm>>2)+1 <= DEPTH.
- On a candidate, latch br_pc = fetch_pc, tgt_pc = fetch_pc + branch_imm, and N.
- IDLE:
  - Candidate and lb_enable -> CAPTURE, with wr_ptr=0.
  - Otherwise remain in IDLE; mispredict is ignored.
- CAPTURE (qualified by fetch_valid):
  - Expected PC is tgt_pc + 4*wr_ptr. A mismatch aborts to IDLE.
  - Any control-flow opcode (1100011/1101111/1100111) at PC != br_pc aborts to IDLE.
  - mispredict aborts to IDLE; lb_enable=0 aborts to IDLE.
  - Aborts never assert flush.
  - Each accepted instruction is written at wr_ptr, then wr_ptr++.
  - When fetch_pc == br_pc, write the branch as entry N-1, issue a read of entry 0, and go to REPLAY.
- REPLAY:
  - lb_active=1; fetch inputs ignored.
  - lb_valid=1 in the first REPLAY cycle, with entry 0: lb_pc = tgt_pc.
  - Storage read is synchronous with 1-cycle latency; rd_ptr runs one entry ahead of the output.
  - Each non-stalled cycle advances the output entry. Wrap goes N-1 -> 0, and replay_count increments on wrap (saturates at 16'hFFFF).
  - stall=1: hold lb_instr, lb_pc, lb_valid and pointers.
  - mispredict (priority over stall): flush=1 for one cycle, resume_pc = br_pc+4, lb_active=0 and lb_valid=0 in that same cycle, then -> IDLE.
  - lb_enable=0 without mispredict: flush=1, resume_pc = PC of the next un-issued entry, -> IDLE.
- N=1 (self-loop, imm=0 is not a candidate; imm=-4 gives N=2) is legal. Behaviour at N=DEPTH is exact; N > DEPTH is never a candidate.
- Asynchronous reset in any state returns to IDLE in the same cycle and clears all outputs; storage contents are don't-care.
- replay_count clears on entry to CAPTURE.
- PC arithmetic is modulo 2^XLEN.

Decomposition:
- Package lsb_pkg:
  - state enum {IDLE, CAPTURE, REPLAY}
  - opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR
  - function is_ctrl(opcode)
- Sub-module lsb_store: DEPTH x ILEN simple dual-port RAM; synchronous write, synchronous 1-cycle read, no reset on the array.
- The controller FSM, pointers and PC datapath live in loop_stream_buffer.

Test Plan:
- Basic loop, DEPTH=16, lb_enable=1: fetch 0x100..0x10C, with the branch at 0x10C and imm=-12. Expect capture and N=4. Then lb_pc must cycle 0x100,0x104,0x108,0x10C,0x100…, lb_active=1, and replay_count=2 after 8 outputs.
- Mispredict exit: mispredict during replay of the above loop, while stall=1 in the same cycle. Expect a single-cycle flush, resume_pc=0x110, lb_active=0 and lb_valid=0 that cycle, IDLE next cycle.
- Size boundary: imm=-60 (N=16) -> captured and replayed. imm=-64 (N=17) -> remains IDLE. A forward branch with imm=+8 -> remains IDLE.
- Capture abort: a JAL at 0x104 inside a candidate loop, or a PC jump from 0x104 to 0x200 during CAPTURE -> IDLE, flush never asserted, lb_active stays 0.
- Stall hold: stall=1 for 3 cycles mid-replay at lb_pc=0x108 -> outputs held constant. After release, next output is 0x10C.
- Disable and reset: lb_enable=0 while output is 0x104 -> flush, resume_pc=0x108. Separately, asynchronous reset asserted mid-replay -> all outputs 0 immediately, state IDLE.
